// File: rtl/v11_pulse_synth.sv
// v11_pulse_synth
// Synthetic detector-pulse source that feeds the shaping-filter chain with an
// ADC-like sample stream, one sample per clk. Every accepted trigger adds a
// linear rise of 2^RISE_LOG2 cycles. The rise is followed by an exponential
// decay with a per-cycle factor of (1 - 2^-DECAY_SHIFT). The filter's pole-zero
// factor M = 2^DECAY_SHIFT - 1 therefore cancels the tail exactly. A trigger
// that arrives during the decay stacks on the remaining tail, so pulses pile up.
//
// Ports
//   clk         in   rising-edge clock
//   reset       in   synchronous, active-low reset
//   trig_valid  in   trigger request
//   trig_amp    in   pulse amplitude in ADC counts, sampled on accept
//   trig_ready  out  trigger can be accepted this cycle (IDLE or DECAY)
//   busy        out  a pulse is in progress
//   adc_data    out  BASELINE + integer part of the accumulator, clipped
//   sat         out  adc_data was clipped for this sample
module v11_pulse_synth #(
   parameter int DATA_W      = 12,
   parameter int FRAC        = 8,
   parameter int RISE_LOG2   = 2,
   parameter int DECAY_SHIFT = 4,
   parameter int BASELINE    = 100
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              trig_valid,
   input  logic [DATA_W-1:0] trig_amp,
   output logic              trig_ready,
   output logic              busy,
   output logic [DATA_W-1:0] adc_data,
   output logic              sat
);

   localparam int ACC_W     = DATA_W + FRAC + 1;
   localparam int STEP_W    = DATA_W + FRAC;
   localparam int INT_W     = ACC_W - FRAC;
   localparam int SUM_W     = INT_W + 1;
   localparam int CNT_W     = (RISE_LOG2 > 0) ? RISE_LOG2 : 1;
   localparam int BASE_CLIP = (BASELINE > (2**DATA_W) - 1) ? (2**DATA_W) - 1 : BASELINE;

   localparam logic [ACC_W-1:0]  ACC_MAX   = '1;
   localparam logic [SUM_W-1:0]  OUT_MAX   = SUM_W'((2**DATA_W) - 1);
   localparam logic [SUM_W-1:0]  BASE_EXT  = SUM_W'(BASELINE);
   localparam logic [DATA_W-1:0] RESET_OUT = DATA_W'(BASE_CLIP);
   localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'((2**RISE_LOG2) - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RISE  = 2'd1,
      DECAY = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [ACC_W-1:0]   acc_q, acc_d;
   logic [STEP_W-1:0]  step_q, step_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [DATA_W-1:0]  adc_data_q, adc_data_d;
   logic               sat_q, sat_d;

   logic               accept;
   logic [STEP_W-1:0]  stepLoad;
   logic [ACC_W:0]     riseSum;
   logic [ACC_W-1:0]   riseAcc;
   logic [ACC_W-1:0]   decayAcc;
   logic [INT_W-1:0]   accInt;
   logic [SUM_W-1:0]   outSum;
   logic               clip;

   // Handshake and status come straight from the registered state. The
   // trigger is also held off while reset is asserted.
   assign trig_ready = reset && (state_q != RISE);
   assign accept     = trig_valid && trig_ready;
   assign busy       = (state_q != IDLE);
   assign adc_data   = adc_data_q;
   assign sat        = sat_q;

   // Arithmetic used by the FSM. The rise add has one spare bit so that
   // overflow can be detected and clamped instead of wrapping. The decay step
   // cannot underflow because it never subtracts more than acc itself.
   always_comb begin
      stepLoad = {trig_amp, {FRAC{1'b0}}} >> RISE_LOG2;
      riseSum  = {1'b0, acc_q} + {{(ACC_W + 1 - STEP_W){1'b0}}, step_q};
      riseAcc  = riseSum[ACC_W] ? ACC_MAX : riseSum[ACC_W-1:0];
      decayAcc = acc_q - (acc_q >> DECAY_SHIFT);
      accInt   = acc_q[ACC_W-1:FRAC];
   end

   // The output sample is built from the accumulator value before this
   // edge's update, which gives exactly one cycle of latency. The integer
   // part can exceed the ADC range when pulses pile up, so the sum is clipped
   // to full scale and the clip is flagged.
   always_comb begin
      outSum     = BASE_EXT + {1'b0, accInt};
      clip       = (outSum > OUT_MAX);
      adc_data_d = clip ? OUT_MAX[DATA_W-1:0] : outSum[DATA_W-1:0];
      sat_d      = clip;
   end

   // Next-state logic. Accepting a trigger loads a new step and rise count
   // but keeps acc, so a trigger during DECAY rides on the existing tail.
   // That accepting edge still applies its normal decay step. When the
   // integer part has reached zero, the tail is finished and acc is cleared.
   // A trigger on that same edge takes priority, so the residual fraction is
   // kept.
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      step_d  = step_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            acc_d = '0;
            if (accept) begin
               step_d  = stepLoad;
               cnt_d   = CNT_MAX;
               state_d = RISE;
            end
         end
         RISE: begin
            acc_d = riseAcc;
            if (cnt_q == '0) begin
               state_d = DECAY;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         DECAY: begin
            if (accept) begin
               acc_d   = decayAcc;
               step_d  = stepLoad;
               cnt_d   = CNT_MAX;
               state_d = RISE;
            end else if (accInt == '0) begin
               acc_d   = '0;
               state_d = IDLE;
            end else begin
               acc_d = decayAcc;
            end
         end
         default: begin
            acc_d   = '0;
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers. Reset is synchronous and overrides
   // everything, including a pulse in flight.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= IDLE;
         acc_q      <= '0;
         step_q     <= '0;
         cnt_q      <= '0;
         adc_data_q <= RESET_OUT;
         sat_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         acc_q      <= acc_d;
         step_q     <= step_d;
         cnt_q      <= cnt_d;
         adc_data_q <= adc_data_d;
         sat_q      <= sat_d;
      end
   end

endmodule
